control_unit: RTL

Multicycle control FSM for the 8-bit CPU and the counterpart of the datapath. It takes the 4-bit opcode, the ALU zero flag and the memory ready strobe from the datapath and memory. It drives every datapath control input cycle by cycle, plus the memory read/write strobes. Instructions are two bytes: byte 1 is `{opcode[3:0], reg[3:0]}`, byte 2 is an address, immediate or second register in `[7:4]`.

---
 rtl/control_unit_if.sv | 42 ++++
 rtl/control_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// ============================================================================
// control_unit_if : datapath/memory <-> control FSM signal bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface control_unit_if;
    logic [3:0] opcode;
    logic       zero;
    logic       memReady;
    logic       pcSelect;
    logic       pcEnable;
    logic       adrSelect;
    logic       ir1En;
    logic       ir2En;
    logic       regSelect;
    logic       wd3Select;
    logic       regWrite;
    logic       op1Sel;
    logic       op2Sel;
    logic [2:0] aluControl;
    logic       memRead;
    logic       memWrite;
    logic       halted;
    logic       illegal;

    modport master (
        input  opcode, zero, memReady,
        output pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect,
               wd3Select, regWrite, op1Sel, op2Sel, aluControl,
               memRead, memWrite, halted, illegal
    );

    modport slave (
        output opcode, zero, memReady,
        input  pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect,
               wd3Select, regWrite, op1Sel, op2Sel, aluControl,
               memRead, memWrite, halted, illegal
    );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : multicycle control FSM for the 8-bit CPU (two-byte ISA)
// Revision 1.0
// ============================================================================
`default_nettype none

module control_unit (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH1 = 4'd0,
        S_FETCH2 = 4'd1,
        S_DECODE = 4'd2,
        S_ALU    = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_JUMP   = 4'd6,
        S_BRANCH = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;

    state_t state_q, state_d;
    logic   halted_q, halted_d;
    logic   illegal_q, illegal_d;

    logic       w_pc_select, w_pc_enable, w_adr_select, w_ir1_en, w_ir2_en;
    logic       w_reg_select, w_wd3_select, w_reg_write, w_op1_sel, w_op2_sel;
    logic [2:0] w_alu_control;
    logic       w_mem_read, w_mem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH1;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        w_pc_select   = 1'b0;
        w_pc_enable   = 1'b0;
        w_adr_select  = 1'b0;
        w_ir1_en      = 1'b0;
        w_ir2_en      = 1'b0;
        w_reg_select  = 1'b0;
        w_wd3_select  = 1'b0;
        w_reg_write   = 1'b0;
        w_op1_sel     = 1'b0;
        w_op2_sel     = 1'b0;
        w_alu_control = C_ALU_ADD;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;

        case (state_q)
            S_FETCH1, S_FETCH2: begin
                // PC+1 computed by the ALU while the byte is read
                w_mem_read  = 1'b1;
                w_op2_sel   = 1'b1;
                w_pc_enable = bus.memReady;
                if (state_q == S_FETCH1) begin
                    w_ir1_en = bus.memReady;
                    if (bus.memReady) state_d = S_FETCH2;
                end else begin
                    w_ir2_en = bus.memReady;
                    if (bus.memReady) state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    4'h0:                   state_d = S_FETCH1;
                    4'h1, 4'h2, 4'h3, 4'h4: state_d = S_ALU;
                    4'h5:                   state_d = S_MEMRD;
                    4'h6:                   state_d = S_MEMWR;
                    4'h7:                   state_d = S_JUMP;
                    4'h8:                   state_d = S_BRANCH;
                    4'hF:                   state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_ALU: begin
                w_op1_sel    = 1'b1;
                w_wd3_select = 1'b1;
                w_reg_write  = 1'b1;
                case (bus.opcode)
                    4'h2:    w_alu_control = C_ALU_SUB;
                    4'h3:    w_alu_control = C_ALU_AND;
                    4'h4:    w_alu_control = C_ALU_OR;
                    default: w_alu_control = C_ALU_ADD;
                endcase
                state_d = S_FETCH1;
            end
            S_MEMRD: begin
                w_mem_read   = 1'b1;
                w_adr_select = 1'b1;
                w_reg_write  = bus.memReady;
                if (bus.memReady) state_d = S_FETCH1;
            end
            S_MEMWR: begin
                w_mem_write  = 1'b1;
                w_adr_select = 1'b1;
                if (bus.memReady) state_d = S_FETCH1;
            end
            S_JUMP: begin
                w_pc_select = 1'b1;
                w_pc_enable = 1'b1;
                state_d     = S_FETCH1;
            end
            S_BRANCH: begin
                w_op1_sel     = 1'b1;
                w_alu_control = C_ALU_SUB;
                w_pc_select   = 1'b1;
                w_pc_enable   = bus.zero;
                state_d       = S_FETCH1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH1;
        endcase

        halted_d = (state_d == S_HALT);
    end

    // Reset masks every enable/strobe immediately, ahead of the state register
    assign bus.pcSelect   = w_pc_select   & ~reset;
    assign bus.pcEnable   = w_pc_enable   & ~reset;
    assign bus.adrSelect  = w_adr_select  & ~reset;
    assign bus.ir1En      = w_ir1_en      & ~reset;
    assign bus.ir2En      = w_ir2_en      & ~reset;
    assign bus.regSelect  = w_reg_select  & ~reset;
    assign bus.wd3Select  = w_wd3_select  & ~reset;
    assign bus.regWrite   = w_reg_write   & ~reset;
    assign bus.op1Sel     = w_op1_sel     & ~reset;
    assign bus.op2Sel     = w_op2_sel     & ~reset;
    assign bus.aluControl = w_alu_control & {3{~reset}};
    assign bus.memRead    = w_mem_read    & ~reset;
    assign bus.memWrite   = w_mem_write   & ~reset;
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;

endmodule

`default_nettype wire
